// File: rtl/vga_pixel_source.sv
// 1024x768@60 VGA timing with framebuffer fetch, colour-bar pattern
// and pixel-replication upscale; all outputs share one fixed latency.
package vga_pkg;

  typedef struct packed {
    logic       de;
    logic       hs;
    logic       vs;
    logic       fs;
    logic       pat;
    logic [2:0] bar;
  } px_ctl_t;

endpackage

module vga_pixel_source
  import vga_pkg::*;
#(
  parameter int   H_ACT    = 1024,
  parameter int   H_FP     = 24,
  parameter int   H_SYNC   = 136,
  parameter int   H_BP     = 160,
  parameter int   V_ACT    = 768,
  parameter int   V_FP     = 3,
  parameter int   V_SYNC   = 6,
  parameter int   V_BP     = 29,
  parameter logic SYNC_POL = 1'b0,
  parameter int   SCALE    = 2,
  parameter int   RAM_LAT  = 1,
  parameter int   ADDR_W   = 16
) (
  input  logic              clk,
  input  logic              RST_N,
  input  logic              enable,
  input  logic              pattern_sel,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd_en,
  input  logic [11:0]       fb_data,
  output logic [11:0]       vga_out,
  output logic              hsync,
  output logic              vsync,
  output logic              de,
  output logic              frame_start
);

  localparam int H_TOT  = H_ACT + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACT + V_FP + V_SYNC + V_BP;
  localparam int HC_W   = $clog2(H_TOT);
  localparam int VC_W   = $clog2(V_TOT);
  localparam int HS_ON  = H_ACT + H_FP;
  localparam int HS_OFF = HS_ON + H_SYNC;
  localparam int VS_ON  = V_ACT + V_FP;
  localparam int VS_OFF = VS_ON + V_SYNC;
  localparam int BAR_PX = H_ACT / 8;
  localparam int FB_W   = H_ACT >> SCALE;

  logic [HC_W-1:0] h_cnt;
  logic [VC_W-1:0] v_cnt;
  logic            h_last;
  logic            v_last;

  assign h_last = (h_cnt == HC_W'(H_TOT - 1));
  assign v_last = (v_cnt == VC_W'(V_TOT - 1));

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_last) begin
      h_cnt <= '0;
      v_cnt <= v_last ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  logic              h_act;
  logic              v_act;
  logic              act;
  logic              hs_on;
  logic              vs_on;
  logic              fs_on;
  logic              rd_n;
  logic [ADDR_W-1:0] addr_n;
  logic [2:0]        bar_n;
  px_ctl_t           s1_n;

  assign h_act = h_cnt < HC_W'(H_ACT);
  assign v_act = v_cnt < VC_W'(V_ACT);
  assign act   = enable & h_act & v_act;

  assign hs_on = enable
               & (h_cnt >= HC_W'(HS_ON))
               & (h_cnt <  HC_W'(HS_OFF));

  // vsync is a whole-line property
  assign vs_on = enable
               & (v_cnt >= VC_W'(VS_ON))
               & (v_cnt <  VC_W'(VS_OFF));

  assign fs_on = enable
               & (h_cnt == '0)
               & (v_cnt == '0);

  assign rd_n = act & ~pattern_sel;

  assign addr_n = ADDR_W'(
      32'(v_cnt >> SCALE) * 32'(FB_W)
    + 32'(h_cnt >> SCALE));

  assign bar_n = 3'(32'(h_cnt) / 32'(BAR_PX));

  assign s1_n = '{
    de:  act,
    hs:  hs_on,
    vs:  vs_on,
    fs:  fs_on,
    pat: pattern_sel,
    bar: bar_n
  };

  // pipe[0] is stage 1; pipe[RAM_LAT] lines up with fb_data
  px_ctl_t [RAM_LAT:0] pipe;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      pipe     <= '0;
      fb_rd_en <= 1'b0;
      fb_addr  <= '0;
    end else begin
      pipe     <= {pipe[RAM_LAT-1:0], s1_n};
      fb_rd_en <= rd_n;
      if (rd_n) begin
        fb_addr <= addr_n;
      end
    end
  end

  px_ctl_t     o;
  logic [11:0] bar_rgb;
  logic [11:0] pix_n;

  assign o = pipe[RAM_LAT];

  always_comb begin
    bar_rgb = 12'h000;
    unique case (o.bar)
      3'd0: bar_rgb = 12'hFFF;
      3'd1: bar_rgb = 12'hFF0;
      3'd2: bar_rgb = 12'h0FF;
      3'd3: bar_rgb = 12'h0F0;
      3'd4: bar_rgb = 12'hF0F;
      3'd5: bar_rgb = 12'hF00;
      3'd6: bar_rgb = 12'h00F;
      3'd7: bar_rgb = 12'h000;
    endcase
  end

  assign pix_n = !o.de ? 12'h000
               : o.pat ? bar_rgb
               : fb_data;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      vga_out     <= 12'h000;
      de          <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      vga_out     <= pix_n;
      de          <= o.de;
      hsync       <= o.hs ? SYNC_POL : ~SYNC_POL;
      vsync       <= o.vs ? SYNC_POL : ~SYNC_POL;
      frame_start <= o.fs;
    end
  end

endmodule

// File: tb/tb_vga_pixel_source.sv
// Bench: default-size instance plus two shrunken-timing instances
// (RAM_LAT 1/2/3) checked every cycle against a frame-position model.
module tb_vga_pixel_source;

  logic clk;
  logic rst_n;
  logic en;
  logic psel;

  int checks;
  int failures;
  int e;

  logic [15:0] addr_a [3];
  logic        rd_a   [3];
  logic [11:0] fbd_a  [3];
  logic [11:0] vout_a [3];
  logic        hs_a   [3];
  logic        vs_a   [3];
  logic        de_a   [3];
  logic        fs_a   [3];

  typedef struct {
    bit        de;
    bit        hs;
    bit        vs;
    bit        fs;
    bit        rd;
    bit [15:0] addr;
    bit [11:0] pix;
  } rec_t;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k,
                     input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      failures++;
      $display("FAIL %s inst=%0d got=%h expected=%h t=%0t",
               nm, k, a, x, $time);
    end
  endtask

  function automatic bit [11:0] bar_rgb(input int b);
    case (b)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  // What the screen must show for frame position (h,v)
  function automatic rec_t mkrec(
    input bit en_i, input bit pat,
    input int h, input int v,
    input int ha, input int hf, input int hsw,
    input int va, input int vf, input int vsw,
    input bit [15:0] prev);
    rec_t r;
    int   full;
    r.de = en_i && h < ha && v < va;
    r.hs = en_i && h >= ha + hf && h < ha + hf + hsw;
    r.vs = en_i && v >= va + vf && v < va + vf + vsw;
    r.fs = en_i && h == 0 && v == 0;
    r.rd = r.de && !pat;
    full = (v / 4) * (ha / 4) + h / 4;
    r.addr = r.rd ? 16'(full) : prev;
    if (!r.de)
      r.pix = 12'h000;
    else if (pat)
      r.pix = bar_rgb(h / (ha / 8));
    else
      r.pix = 12'(full);
    return r;
  endfunction

  for (genvar k = 0; k < 3; k++) begin : g
    localparam int HA  = (k == 0) ? 1024 : 32;
    localparam int HF  = (k == 0) ? 24   : 2;
    localparam int HSW = (k == 0) ? 136  : 4;
    localparam int HB  = (k == 0) ? 160  : 3;
    localparam int VA  = (k == 0) ? 768  : 16;
    localparam int VF  = (k == 0) ? 3    : 1;
    localparam int VSW = (k == 0) ? 6    : 2;
    localparam int VB  = (k == 0) ? 29   : 2;
    localparam int LAT = k + 1;
    localparam int L   = LAT + 2;
    localparam int HT  = HA + HF + HSW + HB;
    localparam int VT  = VA + VF + VSW + VB;

    logic [11:0] ram [LAT];
    rec_t        q [$];

    always @(posedge clk) begin
      ram[0] <= rd_a[k] ? addr_a[k][11:0] : 12'($urandom);
      for (int i = 1; i < LAT; i++) ram[i] <= ram[i-1];
    end
    assign fbd_a[k] = ram[LAT-1];

    vga_pixel_source #(
      .H_ACT(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_ACT(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
      .SYNC_POL(1'b0), .SCALE(2), .RAM_LAT(LAT), .ADDR_W(16)
    ) dut (
      .clk(clk),
      .RST_N(rst_n),
      .enable(en),
      .pattern_sel(psel),
      .fb_addr(addr_a[k]),
      .fb_rd_en(rd_a[k]),
      .fb_data(fbd_a[k]),
      .vga_out(vout_a[k]),
      .hsync(hs_a[k]),
      .vsync(vs_a[k]),
      .de(de_a[k]),
      .frame_start(fs_a[k])
    );

    // n = clocks since the frame origin; q holds the last L records
    initial begin : model
      int   n;
      rec_t r;
      rec_t z;
      z = '{default: 0};
      n = 0;
      forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
          n = 0;
          q.delete();
          repeat (L) q.push_back(z);
        end else begin
          r = mkrec(en, psel, n % HT, n / HT,
                    HA, HF, HSW, VA, VF, VSW, q[L-1].addr);
          q.push_back(r);
          void'(q.pop_front());
          n = en ? (n + 1) % (HT * VT) : 0;
        end
      end
    end

    initial begin : compare
      forever begin
        @(negedge clk);
        if (q.size() == L) begin
          chk("vga_out",     k, 32'(vout_a[k]), 32'(q[0].pix));
          chk("de",          k, 32'(de_a[k]),   32'(q[0].de));
          chk("hsync",       k, 32'(hs_a[k]),   32'(!q[0].hs));
          chk("vsync",       k, 32'(vs_a[k]),   32'(!q[0].vs));
          chk("frame_start", k, 32'(fs_a[k]),   32'(q[0].fs));
          chk("fb_rd_en",    k, 32'(rd_a[k]),   32'(q[L-1].rd));
          chk("fb_addr",     k, 32'(addr_a[k]), 32'(q[L-1].addr));
        end
      end
    end
  end

  task automatic step_to(input int tgt);
    while (e < tgt) begin
      @(negedge clk);
      e++;
    end
  endtask

  task automatic async_rst();
    #3 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("arst_vga_out", k, 32'(vout_a[k]), 0);
      chk("arst_de",      k, 32'(de_a[k]),   0);
      chk("arst_hsync",   k, 32'(hs_a[k]),   1);
      chk("arst_vsync",   k, 32'(vs_a[k]),   1);
      chk("arst_fb_rd",   k, 32'(rd_a[k]),   0);
      chk("arst_fb_addr", k, 32'(addr_a[k]), 0);
    end
  endtask

  initial begin : main
    int  f1, f2, low, fa, fb, vlow, e0;
    bit  prev;
    checks   = 0;
    failures = 0;
    rst_n = 1'b0;
    en    = 1'b0;
    psel  = 1'b1;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_vga_out", k, 32'(vout_a[k]), 0);
      chk("rst_hsync",   k, 32'(hs_a[k]),   1);
      chk("rst_vsync",   k, 32'(vs_a[k]),   1);
      chk("rst_fs",      k, 32'(fs_a[k]),   0);
    end

    // colour bars from a clean start
    en    = 1'b1;
    rst_n = 1'b1;
    e     = 0;
    for (int i = 1; i <= 5; i++) begin
      step_to(i);
      for (int k = 0; k < 3; k++)
        chk("fs_latency", k, 32'(fs_a[k]), 32'(i == k + 3));
      if (i == 2) chk("de_pre", 0, 32'(de_a[0]), 0);
      if (i == 3) begin
        chk("first_px", 0, 32'(vout_a[0]), 32'h0FFF);
        chk("first_de", 0, 32'(de_a[0]), 1);
      end
    end
    step_to(130);
    chk("px127", 0, 32'(vout_a[0]), 32'h0FFF);
    step_to(131);
    chk("px128", 0, 32'(vout_a[0]), 32'h0FF0);

    f1 = -1;
    for (int i = 0; i < 3000 && f1 < 0; i++) begin
      prev = hs_a[0];
      @(negedge clk);
      e++;
      if (prev && !hs_a[0]) f1 = e;
    end
    chk("hsync_fall", 0, 32'(f1), 32'(1048 + 3));
    low = 0;
    while (hs_a[0] == 1'b0 && low < 2000) begin
      low++;
      @(negedge clk);
      e++;
    end
    chk("hsync_width", 0, 32'(low), 136);
    f2 = -1;
    for (int i = 0; i < 3000 && f2 < 0; i++) begin
      prev = hs_a[0];
      @(negedge clk);
      e++;
      if (prev && !hs_a[0]) f2 = e;
    end
    chk("hsync_period", 0, 32'(f2 - f1), 1344);

    fa = -1;
    fb = -1;
    vlow = 0;
    for (int i = 0; i < 2500 && fb < 0; i++) begin
      @(negedge clk);
      e++;
      if (fs_a[1]) begin
        if (fa < 0) fa = e;
        else fb = e;
      end
      if (fa >= 0 && fb < 0 && !vs_a[1]) vlow++;
    end
    chk("frame_period", 1, 32'(fb - fa), 41 * 21);
    chk("vsync_width",  1, 32'(vlow), 2 * 41);

    // reset mid-frame while a visible pixel is on screen
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (de_a[0] && vout_a[0] != 12'h000) break;
    end
    chk("pre_rst_de", 0, 32'(de_a[0]), 1);
    async_rst();
    psel = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    e = 0;
    step_to(3);
    chk("rst_fs_lat", 0, 32'(fs_a[0]), 1);

    // framebuffer addressing with 4x replication
    step_to(8 * 1344 + 4 + 1);
    chk("addr_4_8", 0, 32'(addr_a[0]), 513);
    chk("rd_4_8",   0, 32'(rd_a[0]), 1);
    step_to(8 * 1344 + 8 + 1);
    chk("addr_8_8", 0, 32'(addr_a[0]), 514);
    step_to(9 * 1344 + 5 + 1);
    chk("addr_5_9", 0, 32'(addr_a[0]), 513);
    step_to(9 * 1344 + 5 + 3);
    chk("pix_5_9",  0, 32'(vout_a[0]), 32'h201);
    chk("de_5_9",   0, 32'(de_a[0]), 1);
    step_to(11 * 1344 + 7 + 1);
    chk("addr_7_11", 0, 32'(addr_a[0]), 513);
    step_to(11 * 1344 + 7 + 3);
    chk("pix_7_11",  0, 32'(vout_a[0]), 32'h201);

    // enable dropped mid-line, then restarted
    e0 = e;
    en = 1'b0;
    step_to(e0 + 2);
    chk("en_drain_de", 0, 32'(de_a[0]), 1);
    step_to(e0 + 3);
    chk("en_off_de",  0, 32'(de_a[0]), 0);
    chk("en_off_pix", 0, 32'(vout_a[0]), 0);
    step_to(e0 + 20);
    chk("idle_hsync", 0, 32'(hs_a[0]), 1);
    chk("idle_vsync", 0, 32'(vs_a[0]), 1);
    chk("idle_fs",    0, 32'(fs_a[0]), 0);
    en = 1'b1;
    e0 = e;
    for (int i = 1; i <= 4; i++) begin
      step_to(e0 + i);
      chk("en_fs_lat", 0, 32'(fs_a[0]), 32'(i == 3));
    end

    // randomized run checked by the model
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      if ($urandom_range(39) == 0) psel = ~psel;
      if (en && $urandom_range(2999) == 0) en = 1'b0;
      else if (!en && $urandom_range(19) == 0) en = 1'b1;
      if (rst_n && $urandom_range(5999) == 0) async_rst();
      else if (!rst_n && $urandom_range(3) == 0) rst_n = 1'b1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_pixel_source.md
Name: vga_pixel_source

Overview:
- Generates 1024x768@60 Hz VGA timing at 65 MHz.
- Fetches 12-bit RGB pixels from an external synchronous framebuffer RAM.
- Drives the 12-bit vga_out bus, plus sync and data-enable, all pipeline-aligned.
- Feeds the downstream RGB output register stage. Framebuffer is stored at reduced resolution and upscaled by pixel replication.

Parameters:
- H_ACT, 1024, active pixels per line
- H_FP, 24, horizontal front porch (clocks)
- H_SYNC, 136, hsync pulse width (clocks)
- H_BP, 160, horizontal back porch (clocks)
- V_ACT, 768, active lines per frame
- V_FP, 3, vertical front porch (lines)
- V_SYNC, 6, vsync pulse width (lines)
- V_BP, 29, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)
- SCALE, 2, log2 upscale factor; framebuffer is (H_ACT>>SCALE) x (V_ACT>>SCALE)
- RAM_LAT, 1, framebuffer read latency in clocks (1..3)
- ADDR_W, 16, framebuffer address width

Ports:
- clk, input, 1, 65 MHz pixel clock
- RST_N, input, 1, asynchronous active-low reset
- enable, input, 1, run timing; when low, the generator idles
- pattern_sel, input, 1, 1 = internal colour-bar pattern, 0 = framebuffer data
- fb_addr, output, ADDR_W, framebuffer read address
- fb_rd_en, output, 1, framebuffer read strobe
- fb_data, input, 12, framebuffer read data {R,G,B}, valid RAM_LAT clocks after fb_rd_en
- vga_out, output, 12, pixel {R[3:0],G[3:0],B[3:0]}, zero when blanked
- hsync, output, 1, horizontal sync
- vsync, output, 1, vertical sync
- de, output, 1, active-video flag aligned with vga_out
- frame_start, output, 1, one-clock pulse aligned with first active pixel (0,0) of each frame

Behaviour:
- Reset: all of the following take effect immediately on RST_N low, asynchronously.
  - Outputs: vga_out=0, de=0, fb_rd_en=0, fb_addr=0, frame_start=0.
  - Syncs go to the inactive level (~SYNC_POL).
  - h_cnt=0, v_cnt=0; all pipeline stages cleared.
- Counters:
  - H_TOT = H_ACT+H_FP+H_SYNC+H_BP (1344 by default).
  - V_TOT = V_ACT+V_FP+V_SYNC+V_BP (806 by default).
  - h_cnt increments each clk while enable=1 and wraps H_TOT-1 -> 0.
  - v_cnt increments on that wrap and wraps V_TOT-1 -> 0.
- Timing regions:
  - Active when h_cnt<H_ACT and v_cnt<V_ACT.
  - hsync asserted for H_ACT+H_FP <= h_cnt < H_ACT+H_FP+H_SYNC.
  - vsync asserted for V_ACT+V_FP <= v_cnt < V_ACT+V_FP+V_SYNC, evaluated per line (whole lines, independent of h_cnt).
- Stage 1 (counter state at cycle t sampled, registered at t+1):
  - fb_rd_en = active.
  - fb_addr = (v_cnt>>SCALE)*(H_ACT>>SCALE) + (h_cnt>>SCALE), unsigned, truncated to ADDR_W.
  - fb_addr holds its last value when fb_rd_en=0.
- Fetch: fb_data is sampled at t+1+RAM_LAT.
- Output stage, registered at t+2+RAM_LAT:
  - vga_out = de ? pixel : 12'h000, where pixel is fb_data or the pattern.
  - hsync, vsync, de and frame_start are delayed through the same number of stages, so all outputs share the fixed latency L = 2+RAM_LAT from counter state.
- Pattern mode:
  - Eight vertical bars, each H_ACT/8 wide, bar index = h_cnt[9:7] at default H_ACT.
  - Colours in order: FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000.
  - fb_rd_en stays 0 while pattern_sel=1.
  - pattern_sel is sampled in stage 1 and piped with the data, so a mid-line change takes effect cleanly at pixel granularity.
- enable low:
  - Counters reset to 0 synchronously and hold.
  - The pipeline drains normally; thereafter de=0, vga_out=0, syncs inactive.
  - Rising enable starts a fresh frame at (0,0).
- Reset mid-frame: the next frame begins at (0,0) on the first clk after RST_N rises.
- frame_start is asserted exactly once per V_TOT*H_TOT clocks.

Test Plan:
- Reset release, enable=1, pattern_sel=1 -> vga_out=FFF with de=1 exactly L=3 clks after first counter cycle; frame_start=1 on that same clk; vga_out=FF0 at pixel 128.
- Count hsync low width and period -> 136 clks low, period 1344, falling edge at pixel 1048; vsync low for 6 lines (8064 clks), period 806 lines.
- pattern_sel=0, fb_data = address echo, RAM_LAT=1 -> pixel (5,9) yields fb_addr=2*256+1=513; pixels (4..7, 8..11) all read 513; vga_out=513[11:0] aligned with de.
- Sweep RAM_LAT=2,3 -> output latency becomes 4 and 5; sync/de alignment with vga_out preserved.
- RST_N pulsed low at h=500, v=300 -> outputs zero and sync inactive asynchronously; after release, frame_start after 3 clks.
- enable deasserted mid-line -> after 3 clks de=0 and vga_out=0; reassert -> frame_start 3 clks later; no partial frame output.
